// File: rtl/mem_access.sv
// MEM-stage data-cache access controller: IDLE -> ACCESS -> DONE handshake between EX/MEM and MEM/WB.
// Optional LL/SC link register compiled in with `define MEM_ACCESS_LLSC_EN.
module mem_access (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        flush,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        LL_in,
  input  logic        SC_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_in,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] load_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] cap_addr, cap_data;
  logic        cap_wr, cap_sc;
  logic        op, start, sc_fail;

  assign op    = MemRead_in | MemWrite_in;
  assign start = (state == IDLE) && op && !flush;

`ifdef MEM_ACCESS_LLSC_EN
  logic        cap_ll;
  logic        link_valid;
  logic [31:0] link_addr;

  // A failing SC never reaches the cache; it resolves straight to DONE.
  assign sc_fail = MemWrite_in && SC_in && !(link_valid && (link_addr == addr_in));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cap_ll     <= 1'b0;
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      if (start)
        cap_ll <= LL_in && !MemWrite_in;
      if ((state == ACCESS) && dhit) begin
        if (!cap_wr && cap_ll) begin
          link_valid <= 1'b1;
          link_addr  <= cap_addr;
        end else if (cap_wr && (cap_sc || (cap_addr == link_addr))) begin
          link_valid <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_ll;
  assign unused_ll = LL_in;
  assign sc_fail   = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = sc_fail ? DONE : ACCESS;
      ACCESS:  if (dhit) next_state = DONE;
      DONE:    if (flush || ihit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields come only from the captured copy, never from live inputs.
  always_comb begin
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    if (state == ACCESS) begin
      dmemREN   = !cap_wr;
      dmemWEN   = cap_wr;
      dmemaddr  = cap_addr;
      dmemstore = cap_data;
    end
    mem_stall = nRST && (start || (state == ACCESS));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_wr    <= 1'b0;
      cap_sc    <= 1'b0;
      load_data <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        cap_addr <= addr_in;
        cap_data <= store_in;
        cap_wr   <= MemWrite_in;
        cap_sc   <= SC_in && MemWrite_in;
        if (sc_fail)
          load_data <= '0;
      end
      if ((state == ACCESS) && dhit) begin
        if (!cap_wr)
          load_data <= dmemload;
        else if (cap_sc)
          load_data <= 32'd1;
      end
      if ((state == DONE) && flush)
        load_data <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table of instructions, scoreboard of expected cache requests,
// plus hand-written reset/flush sequences. LL/SC rows depend on MEM_ACCESS_LLSC_EN.
module tb_mem_access;

  logic        CLK, nRST, ihit, dhit, flush;
  logic        MemRead_in, MemWrite_in, LL_in, SC_in;
  logic [31:0] addr_in, store_in, dmemload;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore, load_data;

  mem_access dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .LL_in(LL_in), .SC_in(SC_in),
    .addr_in(addr_in), .store_in(store_in), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .load_data(load_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd, wr, ll, sc;
    logic        flush_idle, flush_acc, flush_done, chk_load;
    logic [31:0] addr, data, rdata, exp_load;
    int          dhit_cyc, exp_req;
  } vec_t;

  typedef struct {
    logic [31:0] addr, data;
    logic        wr;
  } req_t;

  vec_t vecs[$];
  req_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rd, wr, ll, sc, fi, fa, fd,
                              input logic [31:0] addr, data, rdata,
                              input int dhit_cyc, input logic cl,
                              input logic [31:0] exp_load, input int exp_req);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ll = ll; v.sc = sc;
    v.flush_idle = fi; v.flush_acc = fa; v.flush_done = fd; v.chk_load = cl;
    v.addr = addr; v.data = data; v.rdata = rdata; v.exp_load = exp_load;
    v.dhit_cyc = dhit_cyc; v.exp_req = exp_req;
    return v;
  endfunction

  // Each completed request (strobe with dhit) must match the oldest expected one.
  always @(negedge CLK) begin
    if (nRST && (dmemREN || dmemWEN) && dhit) begin
      if (sb.size() == 0) begin
        chk("unexpected_req", {31'b0, dmemREN | dmemWEN}, 32'd0);
      end else begin
        req_t e;
        e = sb.pop_front();
        chk("req_addr", dmemaddr, e.addr);
        chk("req_wen", {31'b0, dmemWEN}, {31'b0, e.wr});
        chk("req_ren", {31'b0, dmemREN}, {31'b0, !e.wr});
        if (e.wr) chk("req_store", dmemstore, e.data);
      end
    end
  end

  task automatic clear_ops();
    MemRead_in = 0; MemWrite_in = 0; LL_in = 0; SC_in = 0;
    addr_in = '0; store_in = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int nreq, nstall, guard;
    req_t e;
    @(posedge CLK); #1;
    MemRead_in = v.rd; MemWrite_in = v.wr; LL_in = v.ll; SC_in = v.sc;
    addr_in = v.addr; store_in = v.data; flush = v.flush_idle;
    #1;
    chk("idle_stall", {31'b0, mem_stall}, {31'b0, !v.flush_idle});
    if (v.flush_idle) begin
      @(posedge CLK); #1;
      chk("flushed_no_req", {31'b0, dmemREN | dmemWEN}, 32'd0);
      chk("flushed_stall", {31'b0, mem_stall}, 32'd0);
      flush = 0;
      clear_ops();
      return;
    end
    if (v.exp_req > 0) begin
      e.addr = v.addr; e.data = v.data; e.wr = v.wr;
      sb.push_back(e);
    end
    nreq = 0; nstall = 1; guard = 0;
    @(posedge CLK); #1;
    addr_in = ~v.addr; store_in = ~v.data;
    while ((dmemREN || dmemWEN) && guard < 50) begin
      guard++;
      nreq++;
      if (mem_stall) nstall++;
      if (v.flush_acc) flush = 1;
      if (nreq == v.dhit_cyc) begin dhit = 1; dmemload = v.rdata; end
      @(posedge CLK); #1;
      dhit = 0; flush = 0; dmemload = 32'h0BAD0BAD;
    end
    if (guard >= 50) chk("access_timeout", guard, 32'd0);
    chk("req_cycles", nreq, v.exp_req);
    chk("stall_cycles", nstall, 1 + v.exp_req);
    chk("done_stall", {31'b0, mem_stall}, 32'd0);
    if (v.chk_load) chk("done_load", load_data, v.exp_load);
    @(posedge CLK); #1;
    chk("no_reissue", {31'b0, dmemREN | dmemWEN}, 32'd0);
    if (v.flush_done) flush = 1; else ihit = 1;
    @(posedge CLK); #1;
    ihit = 0; flush = 0;
    clear_ops();
    if (v.flush_done) chk("flush_done_load", load_data, 32'd0);
    @(posedge CLK); #1;
    chk("back_idle", {31'b0, dmemREN | dmemWEN | mem_stall}, 32'd0);
  endtask

  initial begin
    vecs.push_back(mk(1,0,0,0, 0,0,0, 32'h40,  32'h0,        32'hDEADBEEF, 3, 1, 32'hDEADBEEF, 3));
    vecs.push_back(mk(0,1,0,0, 0,0,0, 32'h80,  32'h12345678, 32'h0,        1, 0, 32'h0,        1));
    vecs.push_back(mk(1,1,0,0, 0,0,0, 32'h84,  32'hCAFEF00D, 32'h0,        2, 0, 32'h0,        2));
    vecs.push_back(mk(1,0,0,0, 1,0,0, 32'h44,  32'h0,        32'h0,        1, 0, 32'h0,        0));
    vecs.push_back(mk(1,0,0,0, 0,1,0, 32'h48,  32'h0,        32'h0BADF00D, 2, 1, 32'h0BADF00D, 2));
    vecs.push_back(mk(1,0,0,0, 0,0,1, 32'h4C,  32'h0,        32'h13579BDF, 1, 1, 32'h13579BDF, 1));
    vecs.push_back(mk(1,0,1,0, 0,0,0, 32'h100, 32'h0,        32'h00000077, 1, 1, 32'h00000077, 1));
    vecs.push_back(mk(0,1,0,1, 0,0,0, 32'h100, 32'h55,       32'h0,        1, 1, 32'h1,        1));
`ifdef MEM_ACCESS_LLSC_EN
    vecs.push_back(mk(0,1,0,1, 0,0,0, 32'h100, 32'h66,       32'h0,        1, 1, 32'h0,        0));
    vecs.push_back(mk(1,0,1,0, 0,0,0, 32'h100, 32'h0,        32'h00000009, 1, 1, 32'h00000009, 1));
    vecs.push_back(mk(0,1,0,0, 0,0,0, 32'h100, 32'hAA,       32'h0,        1, 0, 32'h0,        1));
    vecs.push_back(mk(0,1,0,1, 0,0,0, 32'h100, 32'hBB,       32'h0,        1, 1, 32'h0,        0));
`else
    vecs.push_back(mk(0,1,0,1, 0,0,0, 32'h100, 32'h66,       32'h0,        1, 1, 32'h1,        1));
`endif
    vecs.push_back(mk(1,0,0,0, 0,0,0, 32'h60,  32'h0,        32'hFEEDFACE, 2, 1, 32'hFEEDFACE, 2));

    // Reset with an op already presented: every output must be forced low.
    nRST = 0; ihit = 0; dhit = 0; flush = 0; dmemload = 32'h0BAD0BAD;
    MemRead_in = 1; MemWrite_in = 0; LL_in = 0; SC_in = 0;
    addr_in = 32'h44; store_in = 32'h99;
    #12;
    chk("rst_ren", {31'b0, dmemREN}, 32'd0);
    chk("rst_wen", {31'b0, dmemWEN}, 32'd0);
    chk("rst_addr", dmemaddr, 32'd0);
    chk("rst_store", dmemstore, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_load", load_data, 32'd0);
    clear_ops();
    nRST = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-ACCESS: strobes drop at once, load_data clears, no retry afterwards.
    @(posedge CLK); #1;
    MemWrite_in = 1; addr_in = 32'h300; store_in = 32'h1;
    @(posedge CLK); #1;
    chk("pre_rst_wen", {31'b0, dmemWEN}, 32'd1);
    #2 nRST = 0;
    #1;
    chk("async_wen", {31'b0, dmemWEN}, 32'd0);
    chk("async_ren", {31'b0, dmemREN}, 32'd0);
    chk("async_stall", {31'b0, mem_stall}, 32'd0);
    chk("async_load", load_data, 32'd0);
    clear_ops();
    #3 nRST = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("no_retry", {31'b0, dmemREN | dmemWEN | mem_stall}, 32'd0);
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have input CLK, 1 bit: clock, all state updates on rising edge.
REQ-002 SHALL have input nRST, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have input ihit, 1 bit: pipeline advance strobe, the same one that clocks the downstream MEM/WB latch.
REQ-004 SHALL have input dhit, 1 bit: data-cache completion for the current request.
REQ-005 SHALL have input flush, 1 bit: squash the instruction currently in MEM.
REQ-006 SHALL have inputs MemRead_in and MemWrite_in, 1 bit each, from the EX/MEM latch.
REQ-007 SHALL have inputs LL_in and SC_in, 1 bit each: load-linked and store-conditional qualifiers.
REQ-008 SHALL have inputs addr_in and store_in, 32 bits each: effective address and store data.
REQ-009 SHALL have input dmemload, 32 bits: read data from the cache.
REQ-010 SHALL have outputs dmemREN and dmemWEN, 1 bit each: cache request strobes.
REQ-011 SHALL have outputs dmemaddr and dmemstore, 32 bits each: cache request address and data.
REQ-012 SHALL have output mem_stall, 1 bit: holds the upstream pipeline.
REQ-013 SHALL have output load_data, 32 bits: to MEM/WB dmemload_in.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-015 IDLE SHALL drive no request.
  - Op present (MemRead_in|MemWrite_in) and !flush: capture addr, data and op type; go to ACCESS next cycle.
  - Otherwise: stay in IDLE.
REQ-016 ACCESS SHALL drive dmemREN or dmemWEN, dmemaddr and dmemstore from the captured values only (never from live inputs).
REQ-017 In ACCESS, on dhit: for a read, register dmemload into load_data; go to DONE next cycle. Without dhit: stay in ACCESS.
REQ-018 DONE SHALL drive no request and hold load_data; on ihit go to IDLE.
REQ-019 mem_stall SHALL equal (IDLE and op present and !flush) or ACCESS; it SHALL be 0 in DONE.
REQ-020 Minimum latency SHALL be 2 cycles from op presentation to DONE (dhit in the first ACCESS cycle).
REQ-021 Exactly one cache request SHALL be issued per instruction; a held op SHALL NOT re-issue while in DONE.
REQ-022 flush SHALL behave as follows:
  - IDLE: op dropped.
  - DONE: return to IDLE next cycle, with load_data cleared to 0.
  - ACCESS: ignored; the access always completes.
REQ-023 ihit in IDLE or ACCESS SHALL have no effect on state.
REQ-024 When MemRead_in and MemWrite_in are both 1, the op SHALL be treated as a write.

Reset
REQ-025 On nRST low, the block SHALL immediately enter IDLE and force to 0: all outputs, load_data, captured registers, and the link register.
REQ-026 Reset asserted during ACCESS SHALL abandon the request with strobes dropped immediately; there is no retry after reset.

Configuration
REQ-027 Macro MEM_ACCESS_LLSC_EN defined SHALL compile in a link register (valid bit plus 32-bit address).
  - LL read completing on dhit: sets valid and stores the address.
  - SC with valid and address match: performs the write, sets load_data to 1 on dhit, clears valid.
  - SC failing: goes IDLE->DONE directly with no request and load_data=0.
  - Any completed non-SC write to the linked address: clears valid.
REQ-028 Macro undefined SHALL leave no link register.
  - LL behaves as a plain read.
  - SC behaves as a plain write with load_data=1 on completion.

Verification
REQ-029 Read 0x00000040, dhit in the 3rd ACCESS cycle, cache returns 0xDEADBEEF -> dmemREN high for 3 cycles, mem_stall high for 4 cycles, DONE with load_data=0xDEADBEEF, IDLE after ihit.
REQ-030 Write 0x12345678 to 0x80, dhit in the 1st ACCESS cycle -> exactly one dmemWEN cycle with dmemaddr=0x80 and dmemstore=0x12345678; no further request while in DONE.
REQ-031 flush with an op in IDLE -> no request and mem_stall=0; flush during ACCESS -> the request completes anyway.
REQ-032 nRST pulsed low in the middle of ACCESS -> dmemREN/dmemWEN drop asynchronously, state is IDLE, load_data=0.
REQ-033 (LLSC_EN) LL 0x100, then SC 0x100 -> write issued, load_data=1; LL 0x100, write to 0x100, SC 0x100 -> no write, load_data=0.
REQ-034 (LLSC_EN undefined) SC 0x100 with no prior LL -> write issued, load_data=1.
